// File: rtl/pu_cfg_axil_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pu_cfg_axil_arbiter
//  Description : Two-requester AXI4-Lite arbiter in front of the
//                ProtectionUnit configuration port. One whole transaction
//                (AW+W+B or AR+R) is owned at a time, round-robin between
//                the boot region loader (r0) and the runtime host (r1).
//  Revision    : 1.0 - initial release
// ============================================================================
module pu_cfg_axil_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    // requester side
    input  logic [1:0]                  S_AWVALID,
    input  logic [1:0]                  S_WVALID,
    input  logic [1:0]                  S_BREADY,
    input  logic [1:0]                  S_ARVALID,
    input  logic [1:0]                  S_RREADY,
    input  logic [2*ADDR_WIDTH-1:0]     S_AWADDR,
    input  logic [2*ADDR_WIDTH-1:0]     S_ARADDR,
    input  logic [5:0]                  S_AWPROT,
    input  logic [5:0]                  S_ARPROT,
    input  logic [2*DATA_WIDTH-1:0]     S_WDATA,
    input  logic [2*DATA_WIDTH/8-1:0]   S_WSTRB,
    output logic [1:0]                  S_AWREADY,
    output logic [1:0]                  S_WREADY,
    output logic [1:0]                  S_BVALID,
    output logic [1:0]                  S_ARREADY,
    output logic [1:0]                  S_RVALID,
    output logic [3:0]                  S_BRESP,
    output logic [3:0]                  S_RRESP,
    output logic [2*DATA_WIDTH-1:0]     S_RDATA,
    // downstream side
    output logic                        M_AWVALID,
    output logic                        M_WVALID,
    output logic                        M_BREADY,
    output logic                        M_ARVALID,
    output logic                        M_RREADY,
    output logic [ADDR_WIDTH-1:0]       M_AWADDR,
    output logic [ADDR_WIDTH-1:0]       M_ARADDR,
    output logic [2:0]                  M_AWPROT,
    output logic [2:0]                  M_ARPROT,
    output logic [DATA_WIDTH-1:0]       M_WDATA,
    output logic [DATA_WIDTH/8-1:0]     M_WSTRB,
    input  logic                        M_AWREADY,
    input  logic                        M_WREADY,
    input  logic                        M_BVALID,
    input  logic                        M_ARREADY,
    input  logic                        M_RVALID,
    input  logic [1:0]                  M_BRESP,
    input  logic [1:0]                  M_RRESP,
    input  logic [DATA_WIDTH-1:0]       M_RDATA,
    // status
    output logic [1:0]                  GRANT,
    output logic                        BUSY
);

    localparam int       c_strb_w   = DATA_WIDTH / 8;
    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_wr_req  = 3'd1;
    localparam logic [2:0] c_wr_resp = 3'd2;
    localparam logic [2:0] c_rd_req  = 3'd3;
    localparam logic [2:0] c_rd_resp = 3'd4;

    logic [2:0] state_q, state_d;
    logic       prio_q, prio_d;
    logic       owner_q, owner_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    // A write needs both AW and W presented; it outranks a read of the same requester.
    logic [1:0] w_req_wr;
    logic [1:0] w_req;
    logic       w_pick;
    assign w_req_wr = S_AWVALID & S_WVALID;
    assign w_req    = w_req_wr | S_ARVALID;
    assign w_pick   = (&w_req) ? prio_q : w_req[1];

    // State register with synchronous reset; a reset abandons any open transaction.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= c_idle;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            owner_q   <= owner_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next-state: grant in IDLE, track AW/W completion independently, hand priority over on completion.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        owner_d   = owner_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            c_idle: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (|w_req) begin
                    owner_d = w_pick;
                    state_d = w_req_wr[w_pick] ? c_wr_req : c_rd_req;
                end
            end
            c_wr_req: begin
                if (M_AWVALID && M_AWREADY) aw_done_d = 1'b1;
                if (M_WVALID && M_WREADY)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    state_d   = c_wr_resp;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            c_wr_resp: begin
                if (M_BVALID && M_BREADY) begin
                    state_d = c_idle;
                    prio_d  = ~owner_q;
                end
            end
            c_rd_req: begin
                if (M_ARVALID && M_ARREADY) state_d = c_rd_resp;
            end
            c_rd_resp: begin
                if (M_RVALID && M_RREADY) begin
                    state_d = c_idle;
                    prio_d  = ~owner_q;
                end
            end
            default: state_d = c_idle;
        endcase
    end

    // Outputs: route only the owner's channel for the current phase; everything else held at 0.
    always_comb begin
        S_AWREADY = '0;
        S_WREADY  = '0;
        S_BVALID  = '0;
        S_ARREADY = '0;
        S_RVALID  = '0;
        S_BRESP   = '0;
        S_RRESP   = '0;
        S_RDATA   = '0;
        M_AWVALID = 1'b0;
        M_WVALID  = 1'b0;
        M_BREADY  = 1'b0;
        M_ARVALID = 1'b0;
        M_RREADY  = 1'b0;
        M_AWADDR  = '0;
        M_ARADDR  = '0;
        M_AWPROT  = '0;
        M_ARPROT  = '0;
        M_WDATA   = '0;
        M_WSTRB   = '0;
        GRANT     = 2'b00;
        BUSY      = 1'b0;
        if (state_q != c_idle) begin
            BUSY     = 1'b1;
            GRANT    = owner_q ? 2'b10 : 2'b01;
            M_AWADDR = S_AWADDR[(owner_q ? ADDR_WIDTH : 0) +: ADDR_WIDTH];
            M_ARADDR = S_ARADDR[(owner_q ? ADDR_WIDTH : 0) +: ADDR_WIDTH];
            M_AWPROT = S_AWPROT[(owner_q ? 3 : 0) +: 3];
            M_ARPROT = S_ARPROT[(owner_q ? 3 : 0) +: 3];
            M_WDATA  = S_WDATA[(owner_q ? DATA_WIDTH : 0) +: DATA_WIDTH];
            M_WSTRB  = S_WSTRB[(owner_q ? c_strb_w : 0) +: c_strb_w];
        end
        case (state_q)
            c_wr_req: begin
                M_AWVALID          = S_AWVALID[owner_q] & ~aw_done_q;
                M_WVALID           = S_WVALID[owner_q] & ~w_done_q;
                S_AWREADY[owner_q] = M_AWREADY & ~aw_done_q;
                S_WREADY[owner_q]  = M_WREADY & ~w_done_q;
            end
            c_wr_resp: begin
                M_BREADY                        = S_BREADY[owner_q];
                S_BVALID[owner_q]               = M_BVALID;
                S_BRESP[(owner_q ? 2 : 0) +: 2] = M_BRESP;
            end
            c_rd_req: begin
                M_ARVALID          = S_ARVALID[owner_q];
                S_ARREADY[owner_q] = M_ARREADY;
            end
            c_rd_resp: begin
                M_RREADY                                         = S_RREADY[owner_q];
                S_RVALID[owner_q]                                = M_RVALID;
                S_RRESP[(owner_q ? 2 : 0) +: 2]                  = M_RRESP;
                S_RDATA[(owner_q ? DATA_WIDTH : 0) +: DATA_WIDTH] = M_RDATA;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
